dmaster_st_elastic_fifo: RTL and testbench
==========================================

DMASTER_ST_ELASTIC_FIFO -- requirements
Module: dmaster_st_elastic_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the Avalon-ST symbol width.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the FIFO entries; it SHALL be a power of 2 and at least 4.
REQ-003 The block SHALL have parameter AW, default log2(DEPTH), meaning the pointer width.
REQ-004 Port clk  input  1  is the single clock; all logic is rising-edge.
REQ-005 Port reset_n  input  1  is the asynchronous, active-low reset.
REQ-006 Port in_valid  input  1  is the sink valid, fed by the upstream timing-adapter output.
REQ-007 Port in_data  input  DATA_W  is the sink data.
REQ-008 Port in_ready  output  1  is the sink ready.
REQ-009 Port out_valid  output  1  is the source valid.
REQ-010 Port out_data  output  DATA_W  is the source data.
REQ-011 Port out_ready  input  1  is the source ready from the downstream consumer.
REQ-012 Port level  output  AW+1  is the count of entries held, including the output register.
REQ-013 Port overflow  output  1  is a sticky flag: a symbol was offered while full.
REQ-014 Port drop_count  output  8  is the saturating count of dropped symbols.
REQ-015 Port overflow_clr  input  1  is a synchronous clear of overflow and drop_count.

Function
REQ-016 The block SHALL accept a symbol when in_valid && in_ready; in_ready SHALL equal (level != DEPTH) and SHALL be driven combinationally from registered state only.
REQ-017 The block SHALL present a symbol when out_valid && out_ready; transfers SHALL preserve order, and no symbol SHALL be duplicated or lost except under REQ-021.
REQ-018 The FIFO SHALL be first-word-fall-through, with out_data/out_valid driven from registers: a symbol written into an empty FIFO in cycle N SHALL appear with out_valid=1 in cycle N+1.
REQ-019 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 Simultaneous accept and present SHALL leave level unchanged; when level=DEPTH, in_ready=0, so no write occurs even if a read occurs in the same cycle.
REQ-021 If in_valid=1 and in_ready=0, the symbol SHALL be dropped, overflow SHALL set on the next edge, and drop_count SHALL increment, saturating at 255.
REQ-022 overflow_clr=1 SHALL clear overflow and set drop_count to 0; a drop in the same cycle SHALL win, giving overflow=1 and drop_count=1.
REQ-023 Read and write pointers SHALL be AW bits and wrap modulo DEPTH; full and empty SHALL be derived from level, not from pointer equality.
REQ-024 level SHALL update on the edge after each transfer; increment and decrement SHALL never take it outside 0..DEPTH.
REQ-025 In simulation only, a message SHALL be displayed on every drop.

Reset
REQ-026 While reset_n=0, outputs SHALL be: out_valid=0, in_ready=0, level=0, overflow=0, drop_count=0, out_data=0, and both pointers SHALL be 0.
REQ-027 In the first cycle after reset_n rises, in_ready SHALL be 1.
REQ-028 Reset asserted mid-operation SHALL discard all contents immediately; storage RAM contents need not be cleared.

Structure
REQ-029 The default DATA_W/DEPTH constants and the drop-counter width (8) SHALL live in the shared dmaster package.
REQ-030 Storage SHALL be one sub-module, dmaster_st_fifo_ram: a simple dual-port RAM with 1 write port and 1 read port, synchronous write, and asynchronous or registered read absorbed by the FWFT output stage.

Verification
REQ-031 Reset, then write 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> out_data 0x11,0x22,0x33 starting one cycle after the first write, with level returning to 0.
REQ-032 With out_ready=0, write 16 symbols 0x00..0x0F -> level=16, in_ready=0; a 17th symbol 0xAA -> overflow=1, drop_count=1; then drain -> 0x00..0x0F are presented and 0xAA is never presented.
REQ-033 With out_ready=0, hold out_valid=1 for 5 cycles -> out_data is stable at the head value; then raise out_ready -> the next symbol appears on the following cycle.
REQ-034 At level=16, read and offer in the same cycle -> level=15, the offered symbol is dropped, and in_ready=1 on the next cycle.
REQ-035 Force 300 drops, then pulse overflow_clr together with one drop -> drop_count is 255 before the pulse and 1 after it, with overflow=1.
REQ-036 Assert reset_n=0 at level=7 -> out_valid=0 and level=0 immediately; after release, write 0x5A -> 0x5A is the first symbol out, with no stale data.

Source files
------------

// File: rtl/dmaster_pkg.sv
// Shared constants and helpers for the dmaster streaming blocks.
// Default symbol width, FIFO depth and the drop-counter width live here.
package dmaster_pkg;

   localparam int DMASTER_DATA_W = 8;
   localparam int DMASTER_DEPTH  = 16;
   localparam int DMASTER_DROP_W = 8;

   // Saturating increment for the drop counter: sticks at all-ones.
   function automatic logic [DMASTER_DROP_W-1:0] sat_inc(input logic [DMASTER_DROP_W-1:0] v);
      return (v == '1) ? v : v + DMASTER_DROP_W'(1);
   endfunction

endpackage

// File: rtl/dmaster_st_fifo_ram.sv
// Simple dual-port storage for the elastic FIFO: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module dmaster_st_fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dmaster_st_elastic_fifo.sv
// First-word-fall-through Avalon-ST elastic FIFO with registered outputs,
// level reporting and sticky overflow / saturating drop accounting.
module dmaster_st_elastic_fifo
   import dmaster_pkg::*;
#(
   parameter int DATA_W = DMASTER_DATA_W,
   parameter int DEPTH  = DMASTER_DEPTH,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      in_valid,
   input  logic [DATA_W-1:0]         in_data,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   input  logic                      out_ready,
   output logic [AW:0]               level,
   output logic                      overflow,
   output logic [DMASTER_DROP_W-1:0] drop_count,
   input  logic                      overflow_clr
);

   // Handshake: a symbol moves on a port only in a cycle where valid and ready
   // are both 1 at the rising edge. Valid never waits on ready; a sink symbol
   // offered while in_ready=0 is dropped and counted rather than held.

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [AW-1:0]             wr_ptr_q;
   logic [AW-1:0]             rd_ptr_q;
   logic [AW-1:0]             rd_ptr_next;
   logic [AW:0]               level_q;
   logic [AW:0]               level_next;
   logic                      in_ready_q;
   logic                      out_valid_q;
   logic [DATA_W-1:0]         out_data_q;
   logic [DATA_W-1:0]         head_next;
   logic [DATA_W-1:0]         ram_rdata;
   logic                      overflow_q;
   logic [DMASTER_DROP_W-1:0] drop_count_q;
   logic                      push;
   logic                      pop;
   logic                      drop;
   logic                      has_rest;

   dmaster_st_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (in_data),
      .raddr (rd_ptr_next),
      .rdata (ram_rdata)
   );

   always_comb begin
      push        = in_valid && in_ready_q;
      pop         = out_valid_q && out_ready;
      drop        = in_valid && !in_ready_q;
      rd_ptr_next = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_next  = level_q;
      if (push && !pop) begin
         level_next = level_q + (AW+1)'(1);
      end else if (pop && !push) begin
         level_next = level_q - (AW+1)'(1);
      end
      // The output register mirrors the RAM slot at the next head. When no
      // older entry survives this edge, the incoming symbol becomes the head.
      has_rest = pop ? (level_q > (AW+1)'(1)) : (level_q != '0);
      if (has_rest) begin
         head_next = ram_rdata;
      end else if (push) begin
         head_next = in_data;
      end else begin
         head_next = out_data_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         rd_ptr_q    <= rd_ptr_next;
         level_q     <= level_next;
         in_ready_q  <= (level_next != FULL_LVL);
         out_valid_q <= (level_next != '0);
         out_data_q  <= head_next;
      end
   end

   // A drop coinciding with a clear restarts the count at one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else if (drop) begin
         overflow_q   <= 1'b1;
         drop_count_q <= overflow_clr ? DMASTER_DROP_W'(1) : sat_inc(drop_count_q);
      end else if (overflow_clr) begin
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset_n && drop) begin
         $display("%m: dropped symbol 0x%h at %0t", in_data, $time);
      end
   end
`endif

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign level      = level_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_dmaster_st_elastic_fifo.sv
// Bench for dmaster_st_elastic_fifo: directed vectors, corner sequences and
// random traffic checked against a queue-based reference model.
module tb_dmaster_st_elastic_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int AW     = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_ready = 1'b0;
   logic              overflow_clr = 1'b0;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [AW:0]       level;
   logic              overflow;
   logic [7:0]        drop_count;

   // clock / reset
   always #5 clk = ~clk;

   dmaster_st_elastic_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .level        (level),
      .overflow     (overflow),
      .drop_count   (drop_count),
      .overflow_clr (overflow_clr)
   );

   // reference model state
   logic [DATA_W-1:0] exp_q[$];
   bit                live;
   bit                m_ovf;
   int                m_drops;
   int                n_cmp = 0;
   int                n_bad = 0;

   typedef struct {
      logic              iv;
      logic [DATA_W-1:0] d;
      logic              ordy;
      logic [AW:0]       lvl;
      logic              ov;
      logic [DATA_W-1:0] od;
      logic              od_chk;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic ordy, input logic clr);
      in_valid     = iv;
      in_data      = d;
      out_ready    = ordy;
      overflow_clr = clr;
   endtask

   // One clock: update the model from the inputs, then compare after the edge.
   task automatic cycle();
      bit m_ready;
      bit push;
      bit pop;
      bit drop;
      m_ready = live && (exp_q.size() < DEPTH);
      push    = in_valid && m_ready;
      pop     = (exp_q.size() != 0) && out_ready;
      drop    = in_valid && !m_ready;
      if (pop) begin
         check("pop_data", out_data, exp_q[0]);
         void'(exp_q.pop_front());
      end
      if (push) exp_q.push_back(in_data);
      if (drop) begin
         m_ovf   = 1'b1;
         m_drops = overflow_clr ? 1 : ((m_drops == 255) ? 255 : m_drops + 1);
      end else if (overflow_clr) begin
         m_ovf   = 1'b0;
         m_drops = 0;
      end
      @(posedge clk);
      #1;
      live = 1'b1;
      check("in_ready", in_ready, exp_q.size() < DEPTH);
      check("out_valid", out_valid, exp_q.size() != 0);
      check("level", level, exp_q.size());
      if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drops);
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0, 1'b0);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop_count", drop_count, 0);
      check("rst_out_data", out_data, 0);
      exp_q.delete();
      live    = 1'b0;
      m_ovf   = 1'b0;
      m_drops = 0;
      reset_n = 1'b1;
      cycle();
      check("first_in_ready", in_ready, 1);
   endtask

   initial begin
      vecs[0] = '{iv: 1'b1, d: 8'h11, ordy: 1'b1, lvl: 5'd1, ov: 1'b1, od: 8'h11, od_chk: 1'b1};
      vecs[1] = '{iv: 1'b1, d: 8'h22, ordy: 1'b1, lvl: 5'd1, ov: 1'b1, od: 8'h22, od_chk: 1'b1};
      vecs[2] = '{iv: 1'b1, d: 8'h33, ordy: 1'b1, lvl: 5'd1, ov: 1'b1, od: 8'h33, od_chk: 1'b1};
      vecs[3] = '{iv: 1'b0, d: 8'h00, ordy: 1'b1, lvl: 5'd0, ov: 1'b0, od: 8'h00, od_chk: 1'b0};

      // streaming pass-through
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
         cycle();
         check("vec_level", level, vecs[i].lvl);
         check("vec_valid", out_valid, vecs[i].ov);
         if (vecs[i].od_chk) check("vec_data", out_data, vecs[i].od);
      end

      // fill, overflow, read+offer at full, drain
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0);
         cycle();
      end
      check("full_level", level, 16);
      check("full_in_ready", in_ready, 0);
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      cycle();
      check("ovf_flag", overflow, 1);
      check("ovf_count", drop_count, 1);
      drive(1'b1, 8'hBB, 1'b1, 1'b0);
      cycle();
      check("rdwr_full_level", level, 15);
      check("rdwr_full_ready", in_ready, 1);
      check("rdwr_full_drops", drop_count, 2);
      drive(1'b0, '0, 1'b1, 1'b0);
      for (int i = 1; i < 16; i++) begin
         check("drain_head", out_data, i);
         cycle();
      end
      check("drain_empty", out_valid, 0);

      // backpressure hold
      do_reset();
      drive(1'b1, 8'h41, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 8'h42, 1'b0, 1'b0);
      cycle();
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, 8'h41);
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      cycle();
      check("next_data", out_data, 8'h42);
      cycle();
      check("hold_drained", level, 0);

      // drop counter saturation and clear racing a drop
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'($urandom), 1'b0, 1'b0);
         cycle();
      end
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 8'($urandom), 1'b0, 1'b0);
         cycle();
      end
      check("sat_count", drop_count, 255);
      drive(1'b1, 8'hC3, 1'b0, 1'b1);
      cycle();
      check("clr_drop_count", drop_count, 1);
      check("clr_drop_ovf", overflow, 1);
      drive(1'b0, '0, 1'b0, 1'b1);
      cycle();
      check("clr_count", drop_count, 0);
      check("clr_ovf", overflow, 0);
      drive(1'b0, '0, 1'b1, 1'b0);
      repeat (16) cycle();

      // reset in the middle of traffic
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
         cycle();
      end
      check("pre_rst_level", level, 7);
      drive(1'b0, '0, 1'b0, 1'b0);
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_level", level, 0);
      check("mid_rst_ready", in_ready, 0);
      check("mid_rst_data", out_data, 0);
      exp_q.delete();
      live    = 1'b0;
      m_ovf   = 1'b0;
      m_drops = 0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cycle();
      drive(1'b1, 8'h5A, 1'b1, 1'b0);
      cycle();
      check("post_rst_data", out_data, 8'h5A);
      drive(1'b0, '0, 1'b1, 1'b0);
      cycle();
      check("post_rst_empty", level, 0);

      // random traffic: slow consumer, then fast consumer
      do_reset();
      for (int i = 0; i < 800; i++) begin
         drive($urandom_range(0, 99) < 65, 8'($urandom),
               $urandom_range(0, 99) < ((i < 400) ? 35 : 75),
               $urandom_range(0, 99) < 3);
         cycle();
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      repeat (DEPTH + 1) cycle();
      check("final_empty", level, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
